// File: rtl/instr_fetch.sv
// GMRV instruction fetch stage: owns the PC, drives the instruction ROM
// and registers fetched words into the IF/ID slot with a valid/ready handshake.
module instr_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter logic [31:0] ROM_ORIGIN = 32'h0,
  parameter logic [31:0] ROM_LENGTH = 32'h400
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  output logic        oROM_CE,
  output logic        oROM_RD,
  output logic [31:0] oROM_ADDR,
  input  logic [31:0] iROM_DATA,
  input  logic        iREDIRECT,
  input  logic [31:0] iREDIRECT_PC,
  output logic        oIF_VALID,
  output logic [31:0] oIF_INSTR,
  output logic [31:0] oIF_PC,
  input  logic        iID_READY,
  output logic        oFAULT,
  output logic [31:0] oFAULT_PC,
  output logic [31:0] oFETCH_CNT
);

  typedef enum logic {RUN, HALT} state_t;

  // 33-bit window end so ORIGIN+LENGTH cannot wrap
  localparam logic [32:0] ROM_END =
    {1'b0, ROM_ORIGIN} + {1'b0, ROM_LENGTH};

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        vld_q, vld_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ipc_q, ipc_d;
  logic        fault_q, fault_d;
  logic [31:0] fpc_q, fpc_d;
  logic [31:0] cnt_q, cnt_d;

  logic pc_ok, slot_free, take, fetch;

  assign pc_ok = (pc_q[1:0] == 2'b00)
    && ({1'b0, pc_q} >= {1'b0, ROM_ORIGIN})
    && ({1'b0, pc_q} < ROM_END);
  assign slot_free = !vld_q || iID_READY;
  assign take      = vld_q && iID_READY;
  assign fetch     = (state_q == RUN) && slot_free
    && !iREDIRECT && pc_ok;

  assign oROM_CE    = fetch;
  assign oROM_RD    = fetch;
  assign oROM_ADDR  = pc_q;
  assign oIF_VALID  = vld_q;
  assign oIF_INSTR  = instr_q;
  assign oIF_PC     = ipc_q;
  assign oFAULT     = fault_q;
  assign oFAULT_PC  = fpc_q;
  assign oFETCH_CNT = cnt_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    vld_d   = vld_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    fault_d = fault_q;
    fpc_d   = fpc_q;
    cnt_d   = cnt_q + {31'b0, take};
    if (iREDIRECT) begin
      pc_d    = iREDIRECT_PC;
      vld_d   = 1'b0;
      state_d = RUN;
      fault_d = 1'b0;
    end else if ((state_q == RUN) && slot_free && !pc_ok) begin
      state_d = HALT;
      fault_d = 1'b1;
      fpc_d   = pc_q;
      vld_d   = 1'b0;
    end else if (fetch) begin
      instr_d = iROM_DATA;
      ipc_d   = pc_q;
      vld_d   = 1'b1;
      pc_d    = pc_q + 32'd4;
    end else if (take) begin
      // only reachable in HALT: drain the pending word
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      vld_q   <= 1'b0;
      instr_q <= 32'h0;
      ipc_q   <= 32'h0;
      fault_q <= 1'b0;
      fpc_q   <= 32'h0;
      cnt_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      vld_q   <= vld_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      fault_q <= fault_d;
      fpc_q   <= fpc_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed vector table, async reset check,
// then randomized traffic against a transaction-level reference model.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ce, rd;
  logic [31:0] addr, rom_data;
  logic        rdr = 1'b0;
  logic [31:0] tgt = 32'h0;
  logic        vld;
  logic [31:0] instr, ipc;
  logic        rdy = 1'b0;
  logic        fault;
  logic [31:0] fpc, cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    logic [31:0] w;
    case (a)
      32'h0:   w = 32'h00000013;
      32'h4:   w = 32'h00100093;
      32'h8:   w = 32'h00200113;
      32'hC:   w = 32'h00300193;
      default: w = 32'hA5000000 | a;
    endcase
    return w;
  endfunction

  // Disabled ROM drives junk so a capture without CE is visible
  assign rom_data = ce ? rom_word(addr) : 32'hDEADBEEF;

  instr_fetch dut (
    .iCLK(clk), .iRST_N(rst_n),
    .oROM_CE(ce), .oROM_RD(rd), .oROM_ADDR(addr),
    .iROM_DATA(rom_data),
    .iREDIRECT(rdr), .iREDIRECT_PC(tgt),
    .oIF_VALID(vld), .oIF_INSTR(instr), .oIF_PC(ipc),
    .iID_READY(rdy),
    .oFAULT(fault), .oFAULT_PC(fpc), .oFETCH_CNT(cnt)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        rdr;
    logic [31:0] tgt;
    logic        rdy;
    logic        vld;
    logic [31:0] ipc;
    logic [31:0] instr;
    logic        ce;
    logic [31:0] addr;
    logic        fault;
    logic [31:0] fpc;
    logic [31:0] cnt;
  } vec_t;

  function automatic vec_t mk(
    input logic r, input logic [31:0] t, input logic y,
    input logic v, input logic [31:0] p, input logic [31:0] i,
    input logic c, input logic [31:0] a,
    input logic f, input logic [31:0] fp, input logic [31:0] n);
    vec_t x;
    x.rdr = r; x.tgt = t; x.rdy = y;
    x.vld = v; x.ipc = p; x.instr = i;
    x.ce = c; x.addr = a;
    x.fault = f; x.fpc = fp; x.cnt = n;
    return x;
  endfunction

  // reference model state
  logic [31:0] m_pc, m_instr, m_ipc, m_fpc, m_cnt;
  logic        m_vld, m_halt, m_fault;

  function automatic logic in_window(input logic [31:0] p);
    longint lp = longint'(p);
    return (p[1:0] == 2'b00) && lp >= 0 && lp < 64'h400;
  endfunction

  function automatic logic [31:0] pick_tgt();
    int r = $urandom_range(0, 9);
    logic [31:0] t;
    if (r <= 5) t = $urandom_range(0, 255) * 4;
    else if (r == 6) t = ($urandom_range(0, 1) != 0) ? 32'h3FC : 32'h3F8;
    else if (r == 7) t = $urandom_range(0, 255) * 4 + $urandom_range(1, 3);
    else if (r == 8) t = 32'h400 + $urandom_range(0, 100) * 4;
    else t = 32'hFFFFFFFC;
    return t;
  endfunction

  vec_t vt[21];

  initial begin
    vt[0]  = mk(0, 0, 1, 0, 0, 0, 1, 32'h0, 0, 0, 0);
    vt[1]  = mk(0, 0, 1, 1, 32'h0, 32'h00000013, 1, 32'h4, 0, 0, 0);
    vt[2]  = mk(0, 0, 1, 1, 32'h4, 32'h00100093, 1, 32'h8, 0, 0, 1);
    vt[3]  = mk(0, 0, 1, 1, 32'h8, 32'h00200113, 1, 32'hC, 0, 0, 2);
    vt[4]  = mk(1, 32'h4, 1, 1, 32'hC, 32'h00300193,
                0, 32'h10, 0, 0, 3);
    vt[5]  = mk(0, 0, 1, 0, 0, 0, 1, 32'h4, 0, 0, 4);
    vt[6]  = mk(0, 0, 0, 1, 32'h4, 32'h00100093, 0, 32'h8, 0, 0, 4);
    vt[7]  = mk(0, 0, 0, 1, 32'h4, 32'h00100093, 0, 32'h8, 0, 0, 4);
    vt[8]  = mk(0, 0, 0, 1, 32'h4, 32'h00100093, 0, 32'h8, 0, 0, 4);
    vt[9]  = mk(0, 0, 1, 1, 32'h4, 32'h00100093, 1, 32'h8, 0, 0, 4);
    vt[10] = mk(1, 32'h20, 0, 1, 32'h8, 32'h00200113,
                0, 32'hC, 0, 0, 5);
    vt[11] = mk(0, 0, 1, 0, 0, 0, 1, 32'h20, 0, 0, 5);
    vt[12] = mk(1, 32'h3FC, 1, 1, 32'h20, 32'hA5000020,
                0, 32'h24, 0, 0, 5);
    vt[13] = mk(0, 0, 1, 0, 0, 0, 1, 32'h3FC, 0, 0, 6);
    vt[14] = mk(0, 0, 1, 1, 32'h3FC, 32'hA50003FC,
                0, 32'h400, 0, 0, 6);
    vt[15] = mk(0, 0, 1, 0, 0, 0, 0, 32'h400, 1, 32'h400, 7);
    vt[16] = mk(1, 32'h0, 1, 0, 0, 0, 0, 32'h400, 1, 32'h400, 7);
    vt[17] = mk(0, 0, 1, 0, 0, 0, 1, 32'h0, 0, 0, 7);
    vt[18] = mk(1, 32'h6, 1, 1, 32'h0, 32'h00000013,
                0, 32'h4, 0, 0, 7);
    vt[19] = mk(0, 0, 1, 0, 0, 0, 0, 32'h6, 0, 0, 8);
    vt[20] = mk(0, 0, 1, 0, 0, 0, 0, 32'h6, 1, 32'h6, 8);

    // reset state while held
    #12;
    chk("rst_vld", {31'b0, vld}, 32'd0);
    chk("rst_cnt", cnt, 32'd0);
    chk("rst_fault", {31'b0, fault}, 32'd0);
    chk("rst_addr", addr, 32'h0);
    chk("rst_ce", {31'b0, ce}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 21; k++) begin
      rdr = vt[k].rdr; tgt = vt[k].tgt; rdy = vt[k].rdy;
      #1;
      chk($sformatf("v%0d_vld", k), {31'b0, vld}, {31'b0, vt[k].vld});
      if (vt[k].vld) begin
        chk($sformatf("v%0d_pc", k), ipc, vt[k].ipc);
        chk($sformatf("v%0d_instr", k), instr, vt[k].instr);
      end
      chk($sformatf("v%0d_ce", k), {31'b0, ce}, {31'b0, vt[k].ce});
      chk($sformatf("v%0d_rd", k), {31'b0, rd}, {31'b0, vt[k].ce});
      chk($sformatf("v%0d_addr", k), addr, vt[k].addr);
      chk($sformatf("v%0d_fault", k), {31'b0, fault},
          {31'b0, vt[k].fault});
      if (vt[k].fault)
        chk($sformatf("v%0d_fpc", k), fpc, vt[k].fpc);
      chk($sformatf("v%0d_cnt", k), cnt, vt[k].cnt);
      @(posedge clk);
      @(negedge clk);
    end

    // async reset mid-HALT, away from any clock edge
    rdr = 1'b0; rdy = 1'b1;
    #2;
    chk("halt_pre_fault", {31'b0, fault}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_vld", {31'b0, vld}, 32'd0);
    chk("arst_instr", instr, 32'h0);
    chk("arst_pc", ipc, 32'h0);
    chk("arst_fault", {31'b0, fault}, 32'd0);
    chk("arst_fpc", fpc, 32'h0);
    chk("arst_cnt", cnt, 32'h0);
    chk("arst_addr", addr, 32'h0);
    chk("arst_ce", {31'b0, ce}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // randomized run against the reference model
    m_pc = 32'h0; m_vld = 0; m_instr = 0; m_ipc = 0;
    m_halt = 0; m_fault = 0; m_fpc = 0; m_cnt = 0;
    for (int c = 0; c < 4000; c++) begin
      logic ok, free, exp_ce, take;
      rdr = ($urandom_range(0, 99) < 8);
      tgt = pick_tgt();
      rdy = ($urandom_range(0, 99) < 70);
      ok = in_window(m_pc);
      free = !m_vld || rdy;
      exp_ce = !m_halt && free && !rdr && ok;
      #1;
      chk("r_ce", {31'b0, ce}, {31'b0, exp_ce});
      chk("r_rd", {31'b0, rd}, {31'b0, exp_ce});
      chk("r_addr", addr, m_pc);
      chk("r_vld", {31'b0, vld}, {31'b0, m_vld});
      if (m_vld) begin
        chk("r_ipc", ipc, m_ipc);
        chk("r_instr", instr, m_instr);
      end
      chk("r_fault", {31'b0, fault}, {31'b0, m_fault});
      if (m_fault) chk("r_fpc", fpc, m_fpc);
      chk("r_cnt", cnt, m_cnt);
      @(posedge clk);
      take = m_vld && rdy;
      if (take) m_cnt = m_cnt + 1;
      if (rdr) begin
        m_pc = tgt; m_vld = 0; m_halt = 0; m_fault = 0;
      end else if (!m_halt && free && !ok) begin
        m_halt = 1; m_fault = 1; m_fpc = m_pc; m_vld = 0;
      end else if (exp_ce) begin
        m_ipc = m_pc; m_instr = rom_word(m_pc);
        m_vld = 1; m_pc = m_pc + 4;
      end else if (take) begin
        m_vld = 0;
      end
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
